// File: rtl/mux5_rr_arbiter.sv
// mux5_rr_arbiter
//   Shares one DW-wide output channel between five valid/ready requesters.
//   Each cycle one winner is picked (round-robin or fixed priority), its
//   one-hot select drives a five-way AND-OR mux, and the winning word is
//   captured in a single output register stage.
//
// Parameters
//   DW    data width of each requester and of the output
//   MODE  0 = round-robin, 1 = fixed priority (in0 highest, in4 lowest)
//
// Ports
//   clk        clock, all state on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   per-requester valid, bit i = requester i
//   in_data    packed requester data, requester i at [i*DW +: DW]
//   in_ready   per-requester accept (combinational), at most one bit high
//   out_valid  output register holds a transfer
//   out_data   registered winner data
//   out_grant  registered one-hot source of out_data, zero when idle
//   out_ready  sink accepts out_data this cycle
module mux5_rr_arbiter #(
  parameter int DW   = 1,
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      in_valid,
  input  logic [5*DW-1:0] in_data,
  output logic [4:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [4:0]      out_grant,
  input  logic            out_ready
);

  localparam int N = 5;

  // Round-robin pick: scan (last+1) mod 5 .. last, first valid wins.
  function automatic logic [N-1:0] pick_rr(input logic [N-1:0] req,
                                           input logic [2:0]   last);
    logic [N-1:0] grant;
    logic         found;
    logic [3:0]   sum;
    logic [2:0]   idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, last} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      idx = sum[2:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

  // Fixed priority pick: lowest valid index wins.
  function automatic logic [N-1:0] pick_fixed(input logic [N-1:0] req);
    logic [N-1:0] grant;
    logic         found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    return grant;
  endfunction

  // Index of the set bit of a one-hot vector (0 if none).
  function automatic logic [2:0] onehot_index(input logic [N-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [2:0]    last_p1;
  logic          vld_p1;
  logic [DW-1:0] data_p1;
  logic [N-1:0]  grant_p1;

  logic          load_p0;
  logic          any_p0;
  logic [N-1:0]  sel_p0;
  logic [DW-1:0] mux_p0;

  // ---- Stage p0: arbitration and data mux (combinational) ----
  always_comb begin
    load_p0 = ~vld_p1 | out_ready;
    any_p0  = |in_valid;
    if (MODE == 1) sel_p0 = pick_fixed(in_valid);
    else           sel_p0 = pick_rr(in_valid, last_p1);
    // Accepts are suppressed under backpressure and while reset is held,
    // since the register will not capture the word in either case.
    in_ready = reset ? '0 : (sel_p0 & {N{load_p0}});
  end

  always_comb begin
    mux_p0 = '0;
    for (int i = 0; i < N; i++) begin
      mux_p0 = mux_p0 | ({DW{sel_p0[i]}} & in_data[i*DW +: DW]);
    end
  end

  // ---- Stage p1: output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      grant_p1 <= '0;
      data_p1  <= '0;
      last_p1  <= 3'd4;
    end else if (load_p0) begin
      if (any_p0) begin
        vld_p1   <= 1'b1;
        grant_p1 <= sel_p0;
        data_p1  <= mux_p0;
        last_p1  <= onehot_index(sel_p0);
      end else begin
        // Idle cycle: data and pointer keep their last values.
        vld_p1   <= 1'b0;
        grant_p1 <= '0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_grant = grant_p1;

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
module tb_mux5_rr_arbiter;

  logic        clk;
  logic        reset;

  logic [4:0]  iv0, ir0, og0;
  logic [39:0] id0;
  logic        ov0, or0;
  logic [7:0]  od0;

  logic [4:0]  iv1, ir1, og1;
  logic [39:0] id1;
  logic        ov1, or1;
  logic [7:0]  od1;

  int checks;
  int failures;

  mux5_rr_arbiter #(.DW(8), .MODE(0)) dut_rr (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv0),
    .in_data   (id0),
    .in_ready  (ir0),
    .out_valid (ov0),
    .out_data  (od0),
    .out_grant (og0),
    .out_ready (or0)
  );

  mux5_rr_arbiter #(.DW(8), .MODE(1)) dut_fp (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv1),
    .in_data   (id1),
    .in_ready  (ir1),
    .out_valid (ov1),
    .out_data  (od1),
    .out_grant (og1),
    .out_ready (or1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05b expected=%05b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    iv0 = 5'b0; or0 = 1'b1; id0 = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    iv1 = 5'b0; or1 = 1'b1; id1 = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state and idle hold
    chk1("rst_out_valid", ov0, 1'b0);
    chk5("rst_out_grant", og0, 5'b00000);
    chk8("rst_out_data",  od0, 8'h00);
    chk5("rst_in_ready",  ir0, 5'b00000);
    chk1("rst_fp_out_valid", ov1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk1("idle_out_valid", ov0, 1'b0);
      chk5("idle_out_grant", og0, 5'b00000);
      chk8("idle_out_data",  od0, 8'h00);
      chk5("idle_in_ready",  ir0, 5'b00000);
    end

    // Round-robin, all requesters valid, no backpressure
    iv0 = 5'b11111;
    #1;
    chk5("rr_first_ready", ir0, 5'b00001);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk1("rr_out_valid", ov0, 1'b1);
      chk8("rr_out_data",  od0, 8'(8'h10 + (k % 5)));
      chk5("rr_out_grant", og0, 5'(1 << (k % 5)));
      #1;
      chk5("rr_in_ready",  ir0, 5'(1 << ((k + 1) % 5)));
    end
    iv0 = 5'b00000;
    tick();
    chk1("rr_idle_valid", ov0, 1'b0);
    chk5("rr_idle_grant", og0, 5'b00000);
    chk8("rr_idle_data_hold", od0, 8'h14);

    // Backpressure with requesters 1 and 3 (pointer at 4)
    iv0 = 5'b01010;
    or0 = 1'b0;
    #1;
    chk5("bp_first_ready", ir0, 5'b00010);
    tick();
    chk8("bp_load_data",  od0, 8'h11);
    chk5("bp_load_grant", og0, 5'b00010);
    chk5("bp_load_ready", ir0, 5'b00000);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1("bp_hold_valid", ov0, 1'b1);
      chk8("bp_hold_data",  od0, 8'h11);
      chk5("bp_hold_grant", og0, 5'b00010);
      chk5("bp_hold_ready", ir0, 5'b00000);
    end
    or0 = 1'b1;
    #1;
    chk5("bp_release_ready", ir0, 5'b01000);
    tick();
    chk8("bp_next_data",  od0, 8'h13);
    chk5("bp_next_grant", og0, 5'b01000);
    chk5("bp_next_ready", ir0, 5'b00010);
    tick();
    chk8("bp_then_data",  od0, 8'h11);
    chk5("bp_then_grant", og0, 5'b00010);
    iv0 = 5'b00000;
    tick();
    chk1("bp_drain_valid", ov0, 1'b0);

    // Single requester 2 for one cycle
    iv0 = 5'b00100;
    #1;
    chk5("single_ready", ir0, 5'b00100);
    tick();
    iv0 = 5'b00000;
    chk1("single_valid", ov0, 1'b1);
    chk5("single_grant", og0, 5'b00100);
    chk8("single_data",  od0, 8'h12);
    #1;
    chk5("single_ready_off", ir0, 5'b00000);
    tick();
    chk1("single_after_valid", ov0, 1'b0);
    chk5("single_after_grant", og0, 5'b00000);
    chk8("single_after_data",  od0, 8'h12);

    // Reset while holding a word under backpressure (pointer at 2)
    iv0 = 5'b00001;
    or0 = 1'b0;
    tick();
    chk1("mid_load_valid", ov0, 1'b1);
    chk8("mid_load_data",  od0, 8'h10);
    iv0   = 5'b11111;
    reset = 1'b1;
    #1;
    chk5("mid_rst_ready_bp", ir0, 5'b00000);
    tick();
    chk1("mid_rst_valid", ov0, 1'b0);
    chk5("mid_rst_grant", og0, 5'b00000);
    or0 = 1'b1;
    #1;
    chk5("mid_rst_ready_load", ir0, 5'b00000);
    tick();
    reset = 1'b0;
    #1;
    chk5("post_rst_ready", ir0, 5'b00001);
    tick();
    chk8("post_rst_data",  od0, 8'h10);
    chk5("post_rst_grant", og0, 5'b00001);
    iv0 = 5'b00000;

    // Fixed priority: requesters 0 and 4 valid
    iv1 = 5'b10001;
    #1;
    chk5("fp_ready0", ir1, 5'b00001);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk8("fp_data0",  od1, 8'h10);
      chk5("fp_grant0", og1, 5'b00001);
      chk5("fp_ready_hold", ir1, 5'b00001);
    end
    iv1 = 5'b10000;
    #1;
    chk5("fp_ready4", ir1, 5'b10000);
    tick();
    chk8("fp_data4",  od1, 8'h14);
    chk5("fp_grant4", og1, 5'b10000);
    iv1 = 5'b00000;
    tick();
    chk1("fp_idle_valid", ov1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
